// File: rtl/fifo_access_arbiter.sv
// Arbitrates NUM_WR producers and one consumer onto a single-port FIFO command port,
// tracks occupancy and sequences a discarding flush. Define FIFO_ARB_CHECK_EN to add err_o.
module fifo_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 128,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        wr_req_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [NUM_WR-1:0]        wr_gnt_o,
  input  logic                     rd_req_i,
  output logic                     rd_gnt_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     flush_i,
  output logic                     flush_busy_o,
  output logic                     flush_done_o,
  output logic [CNT_W-1:0]         count_o,
  output logic                     fifo_en_o,
  output logic                     fifo_wr_rd_o,
  output logic [DATA_W-1:0]        fifo_wdata_o,
  input  logic [DATA_W-1:0]        fifo_rdata_i,
  input  logic                     fifo_valid_i,
  input  logic                     fifo_full_i,
  input  logic                     fifo_empty_i
`ifdef FIFO_ARB_CHECK_EN
  ,output logic                    err_o
`endif
);

  localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE, FLUSH} state_t;
  typedef enum logic {PRI_WRITE, PRI_READ} pri_t;

  state_t              state_q, state_d;
  pri_t                pri_q, pri_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                fifo_en_q, fifo_en_d;
  logic                fifo_wr_rd_q, fifo_wr_rd_d;
  logic [DATA_W-1:0]   fifo_wdata_q, fifo_wdata_d;
  logic                disc_cmd_q, disc_cmd_d;
  logic                disc_q;

  logic [NUM_WR-1:0]   wr_elig;
  logic                rd_elig;
  logic                wr_any;
  logic [PTR_W-1:0]    wr_win;
  logic [PTR_W-1:0]    scan_idx;
  logic [NUM_WR-1:0]   wr_gnt;
  logic                rd_gnt;
  logic                flush_done;

  assign wr_elig = (state_q == IDLE) ? (wr_req_i & {NUM_WR{count_q < DEPTH_C}}) : '0;
  assign rd_elig = (state_q == IDLE) && rd_req_i && (count_q != '0);

  // First eligible writer at or after the round-robin pointer
  always_comb begin
    wr_any   = 1'b0;
    wr_win   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_WR);
      if (!wr_any && wr_elig[scan_idx]) begin
        wr_any = 1'b1;
        wr_win = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pri_d        = pri_q;
    count_d      = count_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_en_d    = 1'b0;
    fifo_wr_rd_d = fifo_wr_rd_q;
    fifo_wdata_d = fifo_wdata_q;
    disc_cmd_d   = 1'b0;
    wr_gnt       = '0;
    rd_gnt       = 1'b0;
    flush_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else if (wr_any && (!rd_elig || pri_q == PRI_WRITE)) begin
          wr_gnt[wr_win] = 1'b1;
          fifo_en_d      = 1'b1;
          fifo_wr_rd_d   = 1'b1;
          fifo_wdata_d   = wr_data_i[wr_win*DATA_W +: DATA_W];
          count_d        = count_q + 1'b1;
          pri_d          = PRI_READ;
          if (int'(wr_win) == NUM_WR - 1) rr_ptr_d = '0;
          else                            rr_ptr_d = wr_win + 1'b1;
        end else if (rd_elig) begin
          rd_gnt       = 1'b1;
          fifo_en_d    = 1'b1;
          fifo_wr_rd_d = 1'b0;
          count_d      = count_q - 1'b1;
          pri_d        = PRI_WRITE;
        end
      end
      FLUSH: begin
        // Exit only once the last discard read has reached the FIFO command port
        if (count_q != '0) begin
          fifo_en_d    = 1'b1;
          fifo_wr_rd_d = 1'b0;
          disc_cmd_d   = 1'b1;
          count_d      = count_q - 1'b1;
        end else if (!disc_cmd_q) begin
          state_d    = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pri_q        <= PRI_WRITE;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      fifo_en_q    <= 1'b0;
      fifo_wr_rd_q <= 1'b0;
      fifo_wdata_q <= '0;
      disc_cmd_q   <= 1'b0;
      disc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pri_q        <= pri_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_en_q    <= fifo_en_d;
      fifo_wr_rd_q <= fifo_wr_rd_d;
      fifo_wdata_q <= fifo_wdata_d;
      disc_cmd_q   <= disc_cmd_d;
      disc_q       <= disc_cmd_q;
    end
  end

  // disc_q is the discard tag delayed to line up with fifo_valid_i
  assign wr_gnt_o     = wr_gnt & {NUM_WR{~rst_i}};
  assign rd_gnt_o     = rd_gnt & ~rst_i;
  assign rd_data_o    = fifo_rdata_i;
  assign rd_valid_o   = fifo_valid_i & ~disc_q & ~rst_i;
  assign flush_busy_o = (state_q == FLUSH) & ~rst_i;
  assign flush_done_o = flush_done & ~rst_i;
  assign count_o      = count_q;
  assign fifo_en_o    = fifo_en_q;
  assign fifo_wr_rd_o = fifo_wr_rd_q;
  assign fifo_wdata_o = fifo_wdata_q;

`ifdef FIFO_ARB_CHECK_EN
  logic             err_q;
  logic             chk_q;
  logic             rd_prev_q;
  logic [CNT_W-1:0] snap_q;

  // FIFO status reflects a command one cycle after the count moved
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      chk_q     <= 1'b0;
      rd_prev_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      chk_q     <= fifo_en_q;
      snap_q    <= count_q;
      rd_prev_q <= fifo_en_q & ~fifo_wr_rd_q;
      if ((chk_q && ((fifo_full_i != (snap_q == DEPTH_C)) ||
                     (fifo_empty_i != (snap_q == '0)))) ||
          (fifo_valid_i && !rd_prev_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_status;
  assign unused_status = fifo_full_i ^ fifo_empty_i;
`endif

endmodule
